// File: rtl/zip_wb_pkg.sv
// Shared types and constants for the ALU writeback arbiter.
// Flag bit positions and the queued ALU entry layout live here.
package zip_wb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam int FLG_V = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 0;

  typedef struct packed {
    logic          wr;
    logic          wf;
    logic          illegal;
    logic [AW-1:0] rd;
    logic [DW-1:0] c;
    logic [3:0]    f;
  } alu_ent_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry skid FIFO holding ALU results while loads own the
// register-file write port.
module wb_skid_fifo
  import zip_wb_pkg::*;
#(
  parameter type T = alu_ent_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  T           data_i,
  output T           data_o,
  output logic [1:0] count_o,
  output logic       empty_o,
  output logic       full_o
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = cnt_q[1];

endmodule

// File: rtl/alu_wb_arbiter.sv
// Merges ALU results and load returns onto the single register-file
// write port; loads always win, ALU results queue behind them.
module alu_wb_arbiter
  import zip_wb_pkg::*;
#(
  parameter int AW = zip_wb_pkg::AW,
  parameter int DW = zip_wb_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_alu_valid,
  input  logic          i_alu_wr,
  input  logic          i_alu_wf,
  input  logic [AW-1:0] i_alu_reg,
  input  logic [DW-1:0] i_alu_c,
  input  logic [3:0]    i_alu_f,
  input  logic          i_alu_illegal,
  output logic          o_alu_busy,
  input  logic          i_mem_valid,
  input  logic [AW-1:0] i_mem_reg,
  input  logic [DW-1:0] i_mem_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_reg,
  output logic [DW-1:0] o_wr_data,
  output logic [3:0]    o_flags,
  output logic          o_illegal
);

  typedef struct packed {
    logic          wr;
    logic          wf;
    logic          illegal;
    logic [AW-1:0] rd;
    logic [DW-1:0] c;
    logic [3:0]    f;
  } ent_t;

  ent_t       alu_ent;
  ent_t       head;
  ent_t       ret;
  logic       alu_in;
  logic       push;
  logic       pop;
  logic       bypass;
  logic       ret_alu;
  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] fifo_cnt;
  logic [1:0] cnt_nxt;

  logic          wr_en_d, wr_en_q;
  logic [AW-1:0] wr_reg_d, wr_reg_q;
  logic [DW-1:0] wr_data_d, wr_data_q;
  logic [3:0]    flags_d, flags_q;
  logic          illegal_d, illegal_q;
  logic          busy_d, busy_q;

  always_comb begin
    alu_ent         = '0;
    alu_ent.wr      = i_alu_wr;
    alu_ent.wf      = i_alu_wf;
    alu_ent.illegal = i_alu_illegal;
    alu_ent.rd      = i_alu_reg;
    alu_ent.c       = i_alu_c;
    alu_ent.f       = i_alu_f;
  end

  // Bypass only when nothing older is queued, keeping arrival order.
  assign alu_in  = i_alu_valid && !i_clear;
  assign pop     = !i_mem_valid && !fifo_empty && !i_clear;
  assign bypass  = !i_mem_valid && fifo_empty && alu_in;
  assign push    = alu_in && !bypass && (!fifo_full || pop);
  assign ret_alu = pop || bypass;
  assign ret     = pop ? head : alu_ent;
  assign cnt_nxt = i_clear ? 2'd0
                 : fifo_cnt + 2'(push) - 2'(pop);

  wb_skid_fifo #(.T(ent_t)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (i_clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (alu_ent),
    .data_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    flags_d   = flags_q;
    illegal_d = 1'b0;
    busy_d    = (cnt_nxt != 2'd0);
    unique case (1'b1)
      i_mem_valid: begin
        wr_en_d   = 1'b1;
        wr_reg_d  = i_mem_reg;
        wr_data_d = i_mem_data;
      end
      ret_alu: begin
        if (ret.illegal) begin
          illegal_d = 1'b1;
        end else begin
          wr_en_d = ret.wr;
          if (ret.wr) begin
            wr_reg_d  = ret.rd;
            wr_data_d = ret.c;
          end
          if (ret.wf) begin
            flags_d = {ret.f[FLG_V], ret.f[FLG_N],
                       ret.f[FLG_C], ret.f[FLG_Z]};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      flags_q   <= 4'd0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_reg   = wr_reg_q;
  assign o_wr_data  = wr_data_q;
  assign o_flags    = flags_q;
  assign o_illegal  = illegal_q;
  assign o_alu_busy = busy_q;

endmodule
